// File: rtl/coef_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : coef_loader_if
//  Description : Valid/ready word stream feeding the coefficient loader.
//                The master drives in_data/in_valid; the slave (loader)
//                answers with in_ready.
//    in_data  : WORD_W-bit stream word
//    in_valid : in_data carries a word this cycle
//    in_ready : loader takes the word this cycle
//  Revision    : 1.0  initial release
// ============================================================================
interface coef_loader_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface : coef_loader_if
`default_nettype wire

// File: rtl/coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : coef_loader
//  Description : Loads an image row and NUM_NODES weight rows from a word
//                stream into registered buffers on request from the ANN
//                controller.
//    clk                  : single clock, rising edge
//    rst                  : asynchronous active-high reset
//    request_coef         : one-cycle load request
//    coef_select          : 0 = image then weights, 1 = weights only
//    s_in                 : stream slave (in_data / in_valid / in_ready)
//    image                : IMAGE_SIZE registered words
//    weights              : NUM_NODES x IMAGE_SIZE registered words
//    image_weights_loaded : one-cycle pulse when a load completes
//    busy                 : loader is not idle
//    req_overrun          : sticky, a request arrived while not idle
//  Revision    : 1.0  initial release
// ============================================================================
module coef_loader #(
    parameter int IMAGE_SIZE = 64,
    parameter int NUM_NODES  = 16,
    parameter int WORD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_coef,
    input  logic              coef_select,
    coef_loader_if.slave      s_in,
    output logic [WORD_W-1:0] image   [IMAGE_SIZE],
    output logic [WORD_W-1:0] weights [NUM_NODES][IMAGE_SIZE],
    output logic              image_weights_loaded,
    output logic              busy,
    output logic              req_overrun
);

    // Counter widths; kept at least one bit so degenerate sizes still build.
    localparam int c_WORD_CNT_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int c_NODE_CNT_W = (NUM_NODES  > 1) ? $clog2(NUM_NODES)  : 1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_LOAD_IMAGE   = 2'd1,
        ST_LOAD_WEIGHTS = 2'd2,
        ST_DONE         = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_WORD_CNT_W-1:0] r_word_cnt;
    logic [c_NODE_CNT_W-1:0] r_node_cnt;
    logic                    r_req_overrun;

    logic [WORD_W-1:0]       r_image   [IMAGE_SIZE];
    logic [WORD_W-1:0]       r_weights [NUM_NODES][IMAGE_SIZE];

    logic                    w_in_ready;
    logic                    w_busy;
    logic                    w_loaded;
    logic                    w_accept;
    logic                    w_last_word;
    logic                    w_last_node;
    logic                    w_start;
    logic                    w_img_we;
    logic                    w_wt_we;
    logic [NUM_NODES-1:0]    w_row_we;

    // ------------------------------------------------------------------
    // Handshake and counter terminal decodes
    // ------------------------------------------------------------------
    assign w_accept    = s_in.in_valid && w_in_ready;
    assign w_last_word = (r_word_cnt == c_WORD_CNT_W'(IMAGE_SIZE - 1));
    assign w_last_node = (r_node_cnt == c_NODE_CNT_W'(NUM_NODES - 1));
    assign w_start     = (r_state == ST_IDLE) && request_coef;
    assign w_img_we    = (r_state == ST_LOAD_IMAGE)   && w_accept;
    assign w_wt_we     = (r_state == ST_LOAD_WEIGHTS) && w_accept;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs. in_ready depends only on
    // the registered state, so upstream sees no path from in_valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b1;
        w_loaded    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (request_coef) begin
                    w_state_nxt = coef_select ? ST_LOAD_WEIGHTS : ST_LOAD_IMAGE;
                end
            end
            ST_LOAD_IMAGE: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last_word) begin
                    w_state_nxt = ST_LOAD_WEIGHTS;
                end
            end
            ST_LOAD_WEIGHTS: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last_word && w_last_node) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_loaded    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word / node counters. The word counter wraps after the last word of
    // a row; in the weight phase that wrap advances the node counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_node_cnt <= '0;
        end else if (w_start) begin
            r_word_cnt <= '0;
            r_node_cnt <= '0;
        end else if (w_accept) begin
            if (w_last_word) begin
                r_word_cnt <= '0;
                if (r_state == ST_LOAD_WEIGHTS) begin
                    r_node_cnt <= w_last_node ? '0
                                              : r_node_cnt + c_NODE_CNT_W'(1);
                end
            end else begin
                r_word_cnt <= r_word_cnt + c_WORD_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Overrun flag: any request outside IDLE (DONE included) sets it; the
    // next request taken from IDLE clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_overrun <= 1'b0;
        end else if (request_coef) begin
            r_req_overrun <= (r_state != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Image buffer: only the addressed entry changes, everything else
    // keeps its old contents until rewritten.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < IMAGE_SIZE; k++) begin
                r_image[k] <= '0;
            end
        end else if (w_img_we) begin
            r_image[r_word_cnt] <= s_in.in_data;
        end
    end

    // ------------------------------------------------------------------
    // Weight buffer, one register row per node with a decoded row enable.
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
        assign w_row_we[n] = w_wt_we && (r_node_cnt == c_NODE_CNT_W'(n));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < IMAGE_SIZE; k++) begin
                    r_weights[n][k] <= '0;
                end
            end else if (w_row_we[n]) begin
                r_weights[n][r_word_cnt] <= s_in.in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_in.in_ready          = w_in_ready;
    assign busy                   = w_busy;
    assign image_weights_loaded   = w_loaded;
    assign req_overrun            = r_req_overrun;
    assign image                  = r_image;
    assign weights                = r_weights;

endmodule : coef_loader
`default_nettype wire

// File: tb/tb_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coef_loader
//  Description : Self-checking bench for coef_loader. A driver issues loads
//                with randomized data and valid patterns and pushes the
//                expected completion into a scoreboard; a monitor pops it on
//                each completion pulse and compares latency, flags and the
//                full buffer contents against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coef_loader;

    localparam int IMG = 64;
    localparam int NN  = 16;
    localparam int WW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          request_coef;
    logic          coef_select;
    logic [WW-1:0] image   [IMG];
    logic [WW-1:0] weights [NN][IMG];
    logic          image_weights_loaded;
    logic          busy;
    logic          req_overrun;

    coef_loader_if #(.WORD_W(WW)) s_if ();

    coef_loader #(
        .IMAGE_SIZE (IMG),
        .NUM_NODES  (NN),
        .WORD_W     (WW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .request_coef         (request_coef),
        .coef_select          (coef_select),
        .s_in                 (s_if.slave),
        .image                (image),
        .weights              (weights),
        .image_weights_loaded (image_weights_loaded),
        .busy                 (busy),
        .req_overrun          (req_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the buffers must hold after the current load.
    logic [WW-1:0] m_img [IMG];
    logic [WW-1:0] m_wt  [NN][IMG];

    typedef struct {
        int req_cyc;
        int exp_lat;
        bit exp_ovr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_buffers(input string tag);
        int nbad;
        int fi;
        logic [WW-1:0] fa, fe;
        nbad = 0; fi = -1; fa = '0; fe = '0;
        for (int k = 0; k < IMG; k++) begin
            if (image[k] !== m_img[k]) begin
                if (nbad == 0) begin fi = k; fa = image[k]; fe = m_img[k]; end
                nbad++;
            end
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL %s_image %0d entries differ, first image[%0d] actual=%h required=%h",
                     tag, nbad, fi, fa, fe);
        end
        nbad = 0;
        for (int n = 0; n < NN; n++) begin
            for (int k = 0; k < IMG; k++) begin
                if (weights[n][k] !== m_wt[n][k]) begin
                    if (nbad == 0) begin fi = n * IMG + k; fa = weights[n][k]; fe = m_wt[n][k]; end
                    nbad++;
                end
            end
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL %s_weights %0d entries differ, first weights[%0d][%0d] actual=%h required=%h",
                     tag, nbad, fi / IMG, fi % IMG, fa, fe);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every completion pulse against the scoreboard.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        bit   prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (image_weights_loaded === 1'b1) begin
                if (prev_pulse) begin
                    checks++; failures++;
                    $display("FAIL pulse_width actual=2+ cycles required=1 (cycle %0d)", cyc);
                end else if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pulse actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", 64'(cyc - e.req_cyc + 1), 64'(e.exp_lat));
                    check("busy_in_done", busy, 1'b1);
                    check("overrun_at_done", req_overrun, e.exp_ovr);
                    cmp_buffers("done");
                end
            end
            prev_pulse = (image_weights_loaded === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Driver. vmode: 0 valid always high, 1 toggle starting low,
    // 2 random valid. ovr_word/rst_word < 0 disables that event.
    // ------------------------------------------------------------------
    task automatic do_load(input bit sel, input int vmode, input bit seq_data,
                           input int base, input int ovr_word, input bit done_req,
                           input int rst_word);
        int            n;
        int            ones;
        int            idx;
        bit            rdy_bad;
        bit            v;
        logic [WW-1:0] words[$];
        bit            pat[$];
        exp_t          e;

        n = IMG * (NN + (sel ? 0 : 1));
        for (int i = 0; i < n; i++) begin
            words.push_back(seq_data ? WW'(base + i) : WW'($urandom));
        end
        ones = 0;
        while (ones < n) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (pat.size() % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            pat.push_back(v);
            if (v) ones++;
        end

        if (rst_word < 0) begin
            for (int i = 0; i < n; i++) begin
                int j;
                if (!sel && i < IMG) begin
                    m_img[i] = words[i];
                end else begin
                    j = sel ? i : i - IMG;
                    m_wt[j / IMG][j % IMG] = words[i];
                end
            end
        end

        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = sel;
        if (rst_word < 0) begin
            // request cycle + one cycle per pattern slot + DONE cycle
            e.req_cyc = cyc;
            e.exp_lat = pat.size() + 2;
            e.exp_ovr = (ovr_word >= 0);
            sb.push_back(e);
        end
        @(negedge clk);
        request_coef = 1'b0;
        coef_select  = 1'($urandom);

        idx = 0;
        rdy_bad = 1'b0;
        for (int pc = 0; pc < pat.size(); pc++) begin
            s_if.in_valid = pat[pc];
            s_if.in_data  = pat[pc] ? words[idx] : WW'($urandom);
            if (s_if.in_ready !== 1'b1) rdy_bad = 1'b1;
            if (ovr_word >= 0 && idx == ovr_word && pat[pc]) begin
                request_coef = 1'b1;
                coef_select  = 1'($urandom);
            end else begin
                request_coef = 1'b0;
            end
            if (rst_word >= 0 && idx == rst_word) begin
                rst = 1'b1;
                #1;
                check("in_ready_on_rst", s_if.in_ready, 1'b0);
                check("busy_on_rst", busy, 1'b0);
                check("pulse_on_rst", image_weights_loaded, 1'b0);
                check("overrun_on_rst", req_overrun, 1'b0);
                foreach (m_img[k]) m_img[k] = '0;
                foreach (m_wt[a, b]) m_wt[a][b] = '0;
                cmp_buffers("on_rst");
                request_coef = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                // Stream keeps offering words; none may be taken without a request.
                repeat (6) begin
                    s_if.in_valid = 1'b1;
                    s_if.in_data  = WW'($urandom);
                    @(negedge clk);
                end
                check("in_ready_after_rst", s_if.in_ready, 1'b0);
                check("busy_after_rst", busy, 1'b0);
                cmp_buffers("after_rst");
                s_if.in_valid = 1'b0;
                return;
            end
            if (pat[pc]) idx++;
            @(negedge clk);
        end
        s_if.in_valid = 1'b0;
        request_coef  = 1'b0;
        check("in_ready_during_load", rdy_bad, 1'b0);

        // This negedge lies in the DONE cycle.
        if (done_req) begin
            request_coef = 1'b1;
            coef_select  = 1'($urandom);
            @(negedge clk);
            request_coef = 1'b0;
            check("busy_after_done_req", busy, 1'b0);
            check("overrun_after_done_req", req_overrun, 1'b1);
            check("in_ready_after_done_req", s_if.in_ready, 1'b0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        request_coef  = 1'b0;
        coef_select   = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        foreach (m_img[k]) m_img[k] = '0;
        foreach (m_wt[a, b]) m_wt[a][b] = '0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", s_if.in_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_pulse", image_weights_loaded, 1'b0);
        check("reset_overrun", req_overrun, 1'b0);
        cmp_buffers("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Image + weights, sequential data 0..1087.
        do_load(1'b0, 0, 1'b1, 0, -1, 1'b0, -1);
        check("image_k10", image[10], 16'd10);
        check("weights_2_7", weights[2][7], 16'd199);

        // Weights only, 0xA000+i; image must stay as loaded above.
        do_load(1'b1, 0, 1'b1, 16'hA000, -1, 1'b0, -1);
        check("weights_3_5", weights[3][5], 16'hA0C5);
        check("image_k7_kept", image[7], 16'd7);

        // Same load with in_valid toggling every cycle.
        do_load(1'b1, 1, 1'b1, 16'hA000, -1, 1'b0, -1);

        // Random data and valid, overrun request at word 100.
        do_load(1'b0, 2, 1'b0, 0, 100, 1'b0, -1);

        // Weights-only random load, request on the DONE cycle.
        do_load(1'b1, 2, 1'b0, 0, -1, 1'b1, -1);

        // Reset at word 500 (after an overrun at word 100).
        do_load(1'b0, 0, 1'b0, 0, 100, 1'b0, 500);

        // Fresh loads after reset.
        do_load(1'b0, 0, 1'b0, 0, -1, 1'b0, -1);
        do_load(1'b1, 2, 1'b0, 0, -1, 1'b0, -1);

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_coef_loader
`default_nettype wire

// File: doc/coef_loader.md
COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 64, meaning words per image and words per node weight row.
REQ-002 SHALL have parameter NUM_NODES, default 16, meaning number of node weight rows loaded per request.
REQ-003 SHALL have parameter WORD_W, default 16, meaning data word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port request_coef, input, 1 bit: single-cycle load request from the ANN controller.
REQ-007 SHALL have port coef_select, input, 1 bit: sampled with request_coef; 0 = load image then weights, 1 = load weights only.
REQ-008 SHALL have port in_data, input, WORD_W bits: upstream stream word.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-011 SHALL have port image, output, IMAGE_SIZE x WORD_W: registered image buffer.
REQ-012 SHALL have port weights, output, NUM_NODES x IMAGE_SIZE x WORD_W: registered weight buffer.
REQ-013 SHALL have port image_weights_loaded, output, 1 bit: one-cycle pulse when a load completes.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port req_overrun, output, 1 bit: sticky flag for a request received while busy.

Function
REQ-016 SHALL implement states IDLE, LOAD_IMAGE, LOAD_WEIGHTS, DONE.
REQ-017 SHALL, in IDLE with request_coef=1, go to LOAD_IMAGE if coef_select=0, else LOAD_WEIGHTS, on the next edge; word and node counters cleared.
REQ-018 SHALL drive in_ready=1 exactly when in LOAD_IMAGE or LOAD_WEIGHTS (registered state decode, no combinational path from in_valid).
REQ-019 SHALL accept a word only on a cycle with in_valid=1 and in_ready=1; a cycle with in_valid=0 changes no counter or buffer.
REQ-020 SHALL, in LOAD_IMAGE, write accepted word k (k = 0..IMAGE_SIZE-1) to image[k]; after word IMAGE_SIZE-1, clear the word counter and enter LOAD_WEIGHTS.
REQ-021 SHALL, in LOAD_WEIGHTS, write words in node-major order: node n = 0..NUM_NODES-1, word k = 0..IMAGE_SIZE-1 to weights[n][k].
REQ-022 SHALL use a word counter of clog2(IMAGE_SIZE) bits that wraps to 0 after IMAGE_SIZE-1 and then increments the node counter.
REQ-023 SHALL enter DONE on the edge that accepts word [NUM_NODES-1][IMAGE_SIZE-1].
REQ-024 SHALL assert image_weights_loaded for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL, with coef_select=1, leave image unchanged for the whole load.
REQ-026 SHALL ignore request_coef when not in IDLE, including in DONE, and set req_overrun=1 on that cycle's edge.
REQ-027 SHALL clear req_overrun on the next request accepted from IDLE.
REQ-028 SHALL leave buffer entries not yet rewritten at their previous values during a load.
REQ-029 SHALL give minimum latency from request to pulse of 1 + IMAGE_SIZE*(NUM_NODES + (1 - coef_select)) + 1 cycles with in_valid held high.

Reset
REQ-030 SHALL, on rst=1 at any time (including mid-load), immediately force state IDLE, counters 0, in_ready=0, busy=0, image_weights_loaded=0, req_overrun=0, and all image and weights entries 0.
REQ-031 SHALL, after rst deasserts, accept no word until a new request_coef is received.

Verification
REQ-032 SHALL: with defaults, request with coef_select=0 and stream 0..1087 with in_valid held high -> image[k]=k, weights[n][k]=64+64n+k, and the pulse 1090 cycles after the request.
REQ-033 SHALL: request with coef_select=1 after the REQ-032 load and stream 0xA000+i -> image unchanged, weights[3][5]=0xA0C5, and the pulse after 1026 cycles.
REQ-034 SHALL: toggle in_valid 1/0 every cycle during a weights-only load -> identical buffer contents to REQ-033, and the pulse after 2050 cycles.
REQ-035 SHALL: pulse request_coef at word 100 of a load -> load unaffected and req_overrun=1; the next request from IDLE -> req_overrun=0.
REQ-036 SHALL: assert rst at word 500 -> in_ready=0 at once, all buffers 0, no pulse; a new request then completes normally.
REQ-037 SHALL: assert request_coef on the DONE cycle -> it is ignored, req_overrun=1, and the state returns to IDLE.
